// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler
// Shares one FIR filter engine between CHANNELS requesters. An idle cycle with
// any request picks a winner round-robin, latches its sample block, pulses the
// filter start together with the winner's ack, waits for done (bounded by a
// watchdog), then delivers the result tagged with the requesting channel.
// Optional build macro: FIR_SCHED_PRIORITY_EN gives channel 0 strict priority;
// the remaining channels keep round-robin order among themselves.
module fir_channel_scheduler #(
    parameter int CHANNELS       = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int RESULT_WIDTH   = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clkIn,
    input  logic                           resetIn,
    input  logic [CHANNELS-1:0]            reqIn,
    input  logic [CHANNELS*DATA_WIDTH-1:0] reqDataIn,
    output logic [CHANNELS-1:0]            ackOut,
    output logic                           firStartOut,
    output logic [DATA_WIDTH-1:0]          firDataOut,
    input  logic                           firDoneIn,
    input  logic [RESULT_WIDTH-1:0]        firResultIn,
    output logic [RESULT_WIDTH-1:0]        resultOut,
    output logic [$clog2(CHANNELS)-1:0]    resultChannelOut,
    output logic                           resultValidOut,
    output logic                           timeoutOut,
    output logic                           busyOut
);

    localparam int              CH_W     = $clog2(CHANNELS);
    localparam int              WD_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CH_W:0]   CH_COUNT = (CH_W + 1)'(CHANNELS);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DELIVER} state_t;

    state_t                state;
    state_t                next_state;
    logic [CH_W-1:0]       rr_pointer;
    logic [CH_W-1:0]       grant_channel;
    logic [CH_W-1:0]       grant_idx;
    logic [CH_W-1:0]       grant_offset;
    logic [CH_W-1:0]       next_pointer;
    logic [CH_W:0]         grant_sum;
    logic [CH_W:0]         pointer_sum;
    logic [CHANNELS-1:0]   req_rot;
    logic                  grant_found;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [WD_W-1:0]       watchdog;
    logic                  watchdog_expired;

    assign watchdog_expired = (watchdog == WD_LIMIT);

    // Rotate requests so rr_pointer sits at bit 0, take the first set bit, map back to a channel.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        req_rot      = CHANNELS'({reqIn, reqIn} >> rr_pointer);
        grant_found  = 1'b0;
        grant_offset = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!grant_found && req_rot[k]) begin
                grant_found  = 1'b1;
                grant_offset = CH_W'(k);
            end
        end
        grant_sum = {1'b0, rr_pointer} + {1'b0, grant_offset};
        grant_idx = (grant_sum >= CH_COUNT) ? CH_W'(grant_sum - CH_COUNT) : grant_sum[CH_W-1:0];
`ifdef FIR_SCHED_PRIORITY_EN
        if (reqIn[0]) begin
            grant_idx = '0;
        end
`endif
    end

    // Select the sample block of the channel that wins this cycle.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx == CH_W'(k)) begin
                grant_data = reqDataIn[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointer advances to one past the channel just granted, wrapping at CHANNELS.
    always_comb begin
        pointer_sum  = {1'b0, grant_channel} + (CH_W + 1)'(1);
        next_pointer = (pointer_sum == CH_COUNT) ? '0 : pointer_sum[CH_W-1:0];
    end

    // State register.
    always_ff @(posedge clkIn or posedge resetIn) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (resetIn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        next_state     = state;
        ackOut         = '0;
        firStartOut    = 1'b0;
        resultValidOut = 1'b0;
        busyOut        = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (|reqIn) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                firStartOut = 1'b1;
                ackOut      = CHANNELS'(1) << grant_channel;
                next_state  = S_WAIT;
            end
            S_WAIT: begin
                // Done wins over a watchdog expiry in the same cycle.
                if (firDoneIn) begin
                    next_state = S_DELIVER;
                end else if (watchdog_expired) begin
                    next_state = S_IDLE;
                end
            end
            S_DELIVER: begin
                resultValidOut = 1'b1;
                next_state     = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: grant capture, pointer, watchdog, result capture and timeout pulse.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            rr_pointer       <= '0;
            grant_channel    <= '0;
            firDataOut       <= '0;
            watchdog         <= '0;
            resultOut        <= '0;
            resultChannelOut <= '0;
            timeoutOut       <= 1'b0;
        end else begin
            timeoutOut <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|reqIn) begin
                        firDataOut    <= grant_data;
                        grant_channel <= grant_idx;
                    end
                end
                S_START: begin
                    watchdog <= '0;
`ifdef FIR_SCHED_PRIORITY_EN
                    if (grant_channel != '0) begin
                        rr_pointer <= next_pointer;
                    end
`else
                    rr_pointer <= next_pointer;
`endif
                end
                S_WAIT: begin
                    watchdog <= watchdog + WD_W'(1);
                    if (firDoneIn) begin
                        resultOut        <= firResultIn;
                        resultChannelOut <= grant_channel;
                    end else if (watchdog_expired) begin
                        timeoutOut <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Self-checking bench for fir_channel_scheduler (4 channels, 16-cycle watchdog).
// A transaction-level model predicts grants from the round-robin rule; a
// behavioural filter answers each start after a programmable latency.
module tb_fir_channel_scheduler;

    localparam int CH = 4;
    localparam int DW = 32;
    localparam int RW = 64;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH-1:0]     req = '0;
    logic [CH*DW-1:0]  req_data = '0;
    logic [CH-1:0]     ack;
    logic              fir_start;
    logic [DW-1:0]     fir_data;
    logic              fir_done;
    logic [RW-1:0]     fir_result;
    logic [RW-1:0]     result;
    logic [1:0]        result_ch;
    logic              result_valid;
    logic              timeout;
    logic              busy;

    logic              auto_done = 1'b0;
    logic              manual_done = 1'b0;
    logic [RW-1:0]     next_result = '0;
    logic [RW-1:0]     last_result = '0;
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    int                model_ptr = 0;
    int                lat = 5;
    int                cnt = 0;
    bit                filt_en = 1'b1;

    assign fir_done   = auto_done | manual_done;
    assign fir_result = next_result;

    fir_channel_scheduler #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clkIn(clk), .resetIn(rst), .reqIn(req), .reqDataIn(req_data),
        .ackOut(ack), .firStartOut(fir_start), .firDataOut(fir_data),
        .firDoneIn(fir_done), .firResultIn(fir_result), .resultOut(result),
        .resultChannelOut(result_ch), .resultValidOut(result_valid),
        .timeoutOut(timeout), .busyOut(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural filter: done arrives lat cycles after the edge that delivered start.
    always @(negedge clk) begin
        auto_done = 1'b0;
        if (rst) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) auto_done = filt_en;
            end
            if (fir_start) cnt = lat + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Round-robin rule: first requester at or after the pointer, wrapping.
    function automatic int model_grant(input logic [CH-1:0] r);
        int g;
        int c;
        g = -1;
`ifdef FIR_SCHED_PRIORITY_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < CH; k++) begin
            c = (model_ptr + k) % CH;
            if (g < 0 && r[c]) g = c;
        end
        return g;
    endfunction

    function automatic void model_advance(input int g);
`ifdef FIR_SCHED_PRIORITY_EN
        if (g == 0) return;
`endif
        model_ptr = (g + 1) % CH;
    endfunction

    function automatic logic [CH*DW-1:0] rand_data();
        logic [CH*DW-1:0] d;
        for (int i = 0; i < CH; i++) d[i*DW +: DW] = $urandom;
        return d;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},    64'(ack),          64'd0);
        check({tag, "_start"},  64'(fir_start),    64'd0);
        check({tag, "_fdata"},  64'(fir_data),     64'd0);
        check({tag, "_result"}, result,            64'd0);
        check({tag, "_rch"},    64'(result_ch),    64'd0);
        check({tag, "_valid"},  64'(result_valid), 64'd0);
        check({tag, "_tmo"},    64'(timeout),      64'd0);
        check({tag, "_busy"},   64'(busy),         64'd0);
    endtask

    // One request presented for a single sampling edge, data scrambled right after ack.
    task automatic do_txn(input logic [CH-1:0] mask, input int l,
                          input logic [RW-1:0] res, input logic [CH*DW-1:0] data);
        int g;
        int s;
        int d;
        bit seen;
        logic [DW-1:0] exp_data;
        lat = l;
        next_result = res;
        req = mask;
        req_data = data;
        g = model_grant(mask);
        exp_data = data[g*DW +: DW];
        tick();
        s = cyc;
        check("txn_ack",   64'(ack),       64'(CH'(1) << g));
        check("txn_start", 64'(fir_start), 64'd1);
        check("txn_fdata", 64'(fir_data),  64'(exp_data));
        check("txn_busy",  64'(busy),      64'd1);
        model_advance(g);
        req = '0;
        req_data = ~data;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (result_valid) seen = 1'b1;
        end
        d = cyc - s;
        check("txn_valid_seen", 64'(seen), 64'd1);
        check("txn_deliver_at", 64'(d),    64'(l + 2));
        check("txn_result",     result,    res);
        check("txn_channel",    64'(result_ch), 64'(g));
        check("txn_fdata_hold", 64'(fir_data),  64'(exp_data));
        last_result = res;
        tick();
        check("txn_valid_off",  64'(result_valid), 64'd0);
        check("txn_idle",       64'(busy),         64'd0);
        check("txn_result_hold", result,           res);
    endtask

    // Requests held continuously: check grant order and start-to-start spacing.
    task automatic run_held(input logic [CH-1:0] mask, input int n, input int l);
        int g;
        int last;
        bit seen;
        lat = l;
        next_result = {$urandom, $urandom};
        last_result = next_result;
        req = mask;
        req_data = rand_data();
        last = 0;
        for (int i = 0; i < n; i++) begin
            seen = 1'b0;
            for (int j = 0; j < 60 && !seen; j++) begin
                tick();
                if (fir_start) seen = 1'b1;
            end
            check("held_start_seen", 64'(seen), 64'd1);
            g = model_grant(mask);
            check("held_ack", 64'(ack), 64'(CH'(1) << g));
            if (i > 0) check("held_spacing", 64'(cyc - last), 64'(l + 4));
            last = cyc;
            model_advance(g);
        end
        req = '0;
        seen = 1'b0;
        for (int j = 0; j < 60 && !seen; j++) begin
            tick();
            if (!busy) seen = 1'b1;
        end
        check("held_drain", 64'(seen), 64'd1);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        req = '0;
        manual_done = 1'b0;
        tick();
        rst = 1'b0;
        model_ptr = 0;
    endtask

    initial begin
        logic [CH*DW-1:0] d;
        int s;
        int g;
        bit seen;
        bit vbad;

        // Reset state.
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Single request on channel 2, filter answers 10 cycles after start.
        d = rand_data();
        d[2*DW +: DW] = 32'h1234_ABCD;
        do_txn(4'b0100, 10, 64'hDEAD_BEEF_0000_0001, d);

        // All channels requesting continuously from a fresh pointer.
        do_reset();
        run_held(4'b1111, 5, 5);

        // Filter never answers: watchdog abort.
        filt_en = 1'b0;
        req = 4'b0001;
        req_data = rand_data();
        g = model_grant(req);
        tick();
        s = cyc;
        check("tmo_ack", 64'(ack), 64'(CH'(1) << g));
        model_advance(g);
        req = '0;
        seen = 1'b0;
        vbad = 1'b0;
        for (int j = 0; j < 60 && !seen; j++) begin
            tick();
            if (result_valid) vbad = 1'b1;
            if (timeout) seen = 1'b1;
        end
        check("tmo_seen",     64'(seen),       64'd1);
        check("tmo_at",       64'(cyc - s),    64'(TO + 1));
        check("tmo_no_valid", 64'(vbad),       64'd0);
        check("tmo_idle",     64'(busy),       64'd0);
        check("tmo_result",   result,          last_result);
        tick();
        check("tmo_pulse_off", 64'(timeout),   64'd0);
        check("tmo_idle_next", 64'(busy),      64'd0);
        filt_en = 1'b1;
        do_txn(4'b1000, 3, {$urandom, $urandom}, rand_data());

        // Reset while waiting on the filter.
        lat = 20;
        req = 4'b0100;
        req_data = rand_data();
        g = model_grant(req);
        tick();
        check("rstw_ack", 64'(ack), 64'(CH'(1) << g));
        model_advance(g);
        req = '0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        filt_en = 1'b0;
        tick();
        rst = 1'b0;
        model_ptr = 0;
        tick();
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        vbad = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (result_valid || busy) vbad = 1'b1;
        end
        check("rst_no_result", 64'(vbad), 64'd0);
        filt_en = 1'b1;
        do_txn(4'b1010, 4, {$urandom, $urandom}, rand_data());

        // Single-cycle request on channel 1, data changed right after acceptance.
        do_txn(4'b0010, 2, {$urandom, $urandom}, rand_data());

        // Randomized masks, data and latencies.
        for (int i = 0; i < 12; i++) begin
            do_txn(CH'($urandom_range(1, 15)), $urandom_range(0, 7),
                   {$urandom, $urandom}, rand_data());
        end

        // Held requests from reset with and without channel 0.
        do_reset();
        run_held(4'b1111, 4, 5);
        run_held(4'b1110, 4, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
